mult_div_unit: RTL

- Parametrised multiply/divide unit that extends ALU control beyond the single-cycle mul (func 011100) path.
- Executes MIPS mult/multu/div/divu iteratively, one bit per cycle, into HI/LO registers.
- Also executes mfhi/mflo/mthi/mtlo.
- Sits beside the main ALU. The control path issues operations with a start pulse and stalls the pipeline while the unit is busy.

---
 rtl/mdu_pkg.sv | 34 +++
 rtl/mdu_iter_core.sv | 84 ++++++++
 rtl/mult_div_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared func codes, FSM states and decode helpers for the multiply/divide unit
//
// Purpose: MIPS R-type func codes handled by mult_div_unit, its state
// encoding, and small decode helpers shared by the top level and bench.
// Ports: none (package).
package mdu_pkg;

  localparam logic [5:0] FUNC_MFHI  = 6'b010000;
  localparam logic [5:0] FUNC_MTHI  = 6'b010001;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010;
  localparam logic [5:0] FUNC_MTLO  = 6'b010011;
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // mult/multu/div/divu share the 0110xx prefix; bit 1 selects divide and
  // bit 0 selects unsigned.
  function automatic logic is_iter(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

  // mfhi/mthi/mflo/mtlo share the 0100xx prefix.
  function automatic logic is_move(input logic [5:0] f);
    return f[5:2] == 4'b0100;
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// rtl/mdu_iter_core.sv - one-bit-per-cycle shift-add multiplier / restoring divider datapath
//
// Purpose: holds the 2*WIDTH accumulator (o_hi:o_lo), the divisor /
// multiplicand register and the iteration counter. Operates on magnitudes.
//   mul: {o_hi,o_lo} = i_a * i_b after WIDTH steps
//   div: o_lo = quotient, o_hi = remainder after WIDTH steps
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_load           load i_a into o_lo, i_b into divisor reg, clear o_hi, counter = WIDTH-1
//   i_step           perform one iteration and decrement the counter
//   i_mode_div       1 = divide step, 0 = multiply step
//   i_a, i_b         operand magnitudes
//   o_hi, o_lo       accumulator halves
//   o_last           counter is zero (current step is the final one)
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_mode_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_last
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_hi, r_lo, r_b;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   w_sum, w_shift, w_diff;

  always_comb begin
    w_sum   = {1'b0, r_hi} + {1'b0, r_b};
    // Partial remainder shifted left with the next dividend bit brought in.
    w_shift = {r_hi, r_lo[WIDTH-1]};
    // Remainder stays below the divisor, so bit WIDTH of the difference is
    // set exactly when the trial subtraction goes negative.
    w_diff  = w_shift - {1'b0, r_b};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_hi  <= '0;
      r_lo  <= i_a;
      r_b   <= i_b;
      r_cnt <= CW'(WIDTH - 1);
    end else if (i_step) begin
      r_cnt <= r_cnt - 1'b1;
      if (i_mode_div) begin
        if (!w_diff[WIDTH]) begin
          r_hi <= w_diff[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], 1'b1};
        end else begin
          r_hi <= w_shift[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        // Multiplier bits are consumed from r_lo[0] while product bits
        // shift in from the top, carry included.
        if (r_lo[0]) begin
          r_hi <= w_sum[WIDTH:1];
          r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
        end else begin
          r_hi <= {1'b0, r_hi[WIDTH-1:1]};
          r_lo <= {r_hi[0], r_lo[WIDTH-1:1]};
        end
      end
    end
  end

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_last = (r_cnt == '0);

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MIPS mult/div unit with HI/LO registers and move ops
//
// Purpose: executes mult/multu/div/divu (WIDTH+2 cycle latency, 2 for
// divide-by-zero) and mfhi/mflo/mthi/mtlo, and requests a pipeline stall
// while busy.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_start, i_func   operation request and R-type func field
//   i_rs_val          operand A / dividend / mthi-mtlo source
//   i_rt_val          operand B / divisor
//   o_busy            iterative operation in progress (RUN/FIX)
//   o_done            one-cycle pulse, HI/LO hold the new result
//   o_div_by_zero     one-cycle pulse with o_done for a zero divisor
//   o_stall           pipeline hold: recognised request while busy
//   o_hi, o_lo        HI/LO registers
//   o_rd_data         mfhi/mflo read data, 0 for other func values
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [5:0]       i_func,
  input  logic [WIDTH-1:0] i_rs_val,
  input  logic [WIDTH-1:0] i_rt_val,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic             o_stall,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_rd_data
);

  state_t             r_state;
  logic               r_busy, r_done, r_div_by_zero;
  logic               r_is_div, r_zero_div, r_neg_q, r_neg_r;
  logic [WIDTH-1:0]   r_hi, r_lo;

  logic               w_accept, w_is_div, w_zero_div, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH-1:0]   w_core_hi, w_core_lo, w_quo, w_rem;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic               w_core_last;

  assign w_accept   = i_start && (r_state == ST_IDLE) && is_iter(i_func);
  assign w_is_div   = i_func[1];
  assign w_zero_div = w_is_div && (i_rt_val == '0);
  assign w_a_neg    = !i_func[0] && i_rs_val[WIDTH-1];
  assign w_b_neg    = !i_func[0] && i_rt_val[WIDTH-1];
  // A zero divisor keeps the raw dividend in the core so it can be
  // returned unchanged in HI.
  assign w_a_mag    = (w_a_neg && !w_zero_div) ? -i_rs_val : i_rs_val;
  assign w_b_mag    = w_b_neg ? -i_rt_val : i_rt_val;

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_accept),
    .i_step     (r_state == ST_RUN),
    .i_mode_div (r_is_div),
    .i_a        (w_a_mag),
    .i_b        (w_b_mag),
    .o_hi       (w_core_hi),
    .o_lo       (w_core_lo),
    .o_last     (w_core_last)
  );

  assign w_prod     = {w_core_hi, w_core_lo};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_quo      = r_neg_q ? -w_core_lo : w_core_lo;
  assign w_rem      = r_neg_r ? -w_core_hi : w_core_hi;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_is_div      <= 1'b0;
      r_zero_div    <= 1'b0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_hi          <= '0;
      r_lo          <= '0;
    end else begin
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_is_div   <= w_is_div;
            r_zero_div <= w_zero_div;
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_busy     <= 1'b1;
            r_state    <= w_zero_div ? ST_FIX : ST_RUN;
          end else if (i_start && i_func == FUNC_MTHI) begin
            r_hi <= i_rs_val;
          end else if (i_start && i_func == FUNC_MTLO) begin
            r_lo <= i_rs_val;
          end
        end
        ST_RUN: begin
          if (w_core_last) r_state <= ST_FIX;
        end
        ST_FIX: begin
          if (!r_is_div) begin
            {r_hi, r_lo} <= w_prod_fix;
          end else if (r_zero_div) begin
            r_hi <= w_core_lo;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
          r_done        <= 1'b1;
          r_div_by_zero <= r_zero_div;
          r_busy        <= 1'b0;
          r_state       <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_rd_data = '0;
    if (i_func == FUNC_MFHI)      o_rd_data = r_hi;
    else if (i_func == FUNC_MFLO) o_rd_data = r_lo;
  end

  assign o_stall       = i_start && r_busy && (is_iter(i_func) || is_move(i_func));
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_div_by_zero = r_div_by_zero;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;

endmodule
